// File: rtl/arith_responder.sv
// Registered add/subtract responder: valid/ready request channel in, in-order response FIFO out.
// Optional ARITH_RESP_SAT_EN: saturate stored results on signed 32-bit overflow instead of wrapping.
module arith_responder #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic             i_req_op,
    input  logic [31:0]      i_a,
    input  logic [31:0]      i_b,
    input  logic [TAG_W-1:0] i_req_tag,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [31:0]      o_rsp_result,
    output logic [TAG_W-1:0] o_rsp_tag,
    output logic             o_rsp_ovf,
    output logic [15:0]      o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } state_e;

    state_e           state_q, state_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [15:0]      count_q, count_d;

    logic [31:0]      res_mem_q [DEPTH];
    logic [TAG_W-1:0] tag_mem_q [DEPTH];
    logic             ovf_mem_q [DEPTH];

    logic             req_ready;
    logic             rsp_valid;
    logic             push;
    logic             pop;

    logic [32:0]      a_ext;
    logic [32:0]      b_ext;
    logic [32:0]      sum_ext;
    logic             wr_ovf;
    logic [31:0]      wr_result;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // State register
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q  <= ST_EMPTY;
            occ_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Next-state logic
    always_comb begin
        occ_d    = occ_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d  = count_q + 16'd1;
        end
        if (push && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (!push && pop) begin
            occ_d = occ_q - 1'b1;
        end
        if (occ_d == '0) begin
            state_d = ST_EMPTY;
        end else if (occ_d == OCC_W'(DEPTH)) begin
            state_d = ST_FULL;
        end else begin
            state_d = ST_PARTIAL;
        end
    end

    // Output logic: handshake flags depend on registered state only
    always_comb begin
        req_ready = (state_q != ST_FULL);
        rsp_valid = (state_q != ST_EMPTY);
    end

    assign push = i_req_valid && req_ready;
    assign pop  = rsp_valid && i_rsp_ready;

    always_comb begin
        a_ext   = {i_a[31], i_a};
        b_ext   = {i_b[31], i_b};
        sum_ext = i_req_op ? (a_ext - b_ext) : (a_ext + b_ext);
        wr_ovf  = sum_ext[32] ^ sum_ext[31];
`ifdef ARITH_RESP_SAT_EN
        if (wr_ovf) begin
            wr_result = sum_ext[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            wr_result = sum_ext[31:0];
        end
`else
        wr_result = sum_ext[31:0];
`endif
    end

    // Storage is reset so the head outputs read zero while empty after reset.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                res_mem_q[i] <= '0;
                tag_mem_q[i] <= '0;
                ovf_mem_q[i] <= 1'b0;
            end
        end else if (push) begin
            res_mem_q[wr_ptr_q] <= wr_result;
            tag_mem_q[wr_ptr_q] <= i_req_tag;
            ovf_mem_q[wr_ptr_q] <= wr_ovf;
        end
    end

    assign o_req_ready  = req_ready;
    assign o_rsp_valid  = rsp_valid;
    assign o_rsp_result = res_mem_q[rd_ptr_q];
    assign o_rsp_tag    = tag_mem_q[rd_ptr_q];
    assign o_rsp_ovf    = ovf_mem_q[rd_ptr_q];
    assign o_count      = count_q;

endmodule

// File: tb/tb_arith_responder.sv
// Self-checking bench for arith_responder: vector table plus scoreboard, with back-pressure and reset sequences.
module tb_arith_responder;

    localparam int DEPTH = 2;
    localparam int TAG_W = 4;

    logic             i_clk;
    logic             i_arst_n;
    logic             i_req_valid;
    logic             o_req_ready;
    logic             i_req_op;
    logic [31:0]      i_a;
    logic [31:0]      i_b;
    logic [TAG_W-1:0] i_req_tag;
    logic             o_rsp_valid;
    logic             i_rsp_ready;
    logic [31:0]      o_rsp_result;
    logic [TAG_W-1:0] o_rsp_tag;
    logic             o_rsp_ovf;
    logic [15:0]      o_count;

    arith_responder #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .i_clk        (i_clk),
        .i_arst_n     (i_arst_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_op     (i_req_op),
        .i_a          (i_a),
        .i_b          (i_b),
        .i_req_tag    (i_req_tag),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_result (o_rsp_result),
        .o_rsp_tag    (o_rsp_tag),
        .o_rsp_ovf    (o_rsp_ovf),
        .o_count      (o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] exp_wrap;
        logic [31:0] exp_sat;
        logic        exp_ovf;
    } vec_t;

    typedef struct {
        logic [31:0] result;
        logic [3:0]  tag;
        logic        ovf;
    } rsp_t;

    rsp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] model_cnt = '0;
    logic        bg_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rsp_t model(input logic op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] tag, input logic [31:0] wrap_v,
                                   input logic [31:0] sat_v, input logic ovf);
        rsp_t r;
`ifdef ARITH_RESP_SAT_EN
        r.result = sat_v;
`else
        r.result = wrap_v;
`endif
        r.tag = tag;
        r.ovf = ovf;
        return r;
    endfunction

    // Drives one request; the expected response is queued when acceptance is seen.
    task automatic send(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, input logic [31:0] wrap_v,
                        input logic [31:0] sat_v, input logic ovf);
        bit done = 0;
        i_req_valid = 1'b1;
        i_req_op    = op;
        i_a         = a;
        i_b         = b;
        i_req_tag   = tag;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge i_clk);
            if (o_req_ready) begin
                exp_q.push_back(model(op, a, b, tag, wrap_v, sat_v, ovf));
                @(posedge i_clk);
                #1;
                done = 1;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_accept_timeout: tag %0d never accepted", tag);
        end
        i_req_valid = 1'b0;
    endtask

    // Scoreboard monitor: every response handshake is compared against the queue head.
    always @(negedge i_clk) begin
        rsp_t e;
        check("count", {16'h0, o_count}, {16'h0, model_cnt});
        if (o_rsp_valid && i_rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got tag %0d, expected no response", o_rsp_tag);
            end else begin
                e = exp_q.pop_front();
                check("rsp_result", o_rsp_result, e.result);
                check("rsp_tag", {28'h0, o_rsp_tag}, {28'h0, e.tag});
                check("rsp_ovf", {31'h0, o_rsp_ovf}, {31'h0, e.ovf});
            end
            model_cnt = model_cnt + 16'd1;
        end
    end

    task automatic drain();
        int c = 0;
        while ((exp_q.size() != 0 || o_rsp_valid) && c < 100) begin
            @(posedge i_clk);
            c++;
        end
        #1;
        check("drain_empty", {31'h0, o_rsp_valid}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[8];
    logic [15:0] cnt_base;

    initial begin
        vecs[0] = '{1'b1, 32'd5,         32'd7,         4'd4,  32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0};
        vecs[1] = '{1'b0, 32'h7FFF_FFFF, 32'd1,         4'd5,  32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
        vecs[2] = '{1'b1, 32'h8000_0000, 32'd1,         4'd6,  32'h7FFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[3] = '{1'b0, 32'hFFFF_FFFF, 32'd1,         4'd7,  32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[4] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 4'd8,  32'h0000_0000, 32'h8000_0000, 1'b1};
        vecs[5] = '{1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'd9,  32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
        vecs[6] = '{1'b1, 32'h0000_0000, 32'h8000_0000, 4'd10, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
        vecs[7] = '{1'b0, 32'h1234_5678, 32'h1111_1111, 4'd11, 32'h2345_6789, 32'h2345_6789, 1'b0};

        i_arst_n    = 1'b0;
        i_req_valid = 1'b0;
        i_req_op    = 1'b0;
        i_a         = '0;
        i_b         = '0;
        i_req_tag   = '0;
        i_rsp_ready = 1'b1;
        bg_done     = 1'b0;
        #23;
        check("rst_req_ready", {31'h0, o_req_ready}, 32'h1);
        check("rst_rsp_valid", {31'h0, o_rsp_valid}, 32'h0);
        check("rst_result", o_rsp_result, 32'h0);
        check("rst_tag", {28'h0, o_rsp_tag}, 32'h0);
        check("rst_ovf", {31'h0, o_rsp_ovf}, 32'h0);
        check("rst_count", {16'h0, o_count}, 32'h0);
        @(posedge i_clk);
        #3;
        i_arst_n = 1'b1;

        // Basic add with one-cycle latency
        send(1'b0, 32'd5, 32'd7, 4'd3, 32'd12, 32'd12, 1'b0);
        check("basic_valid", {31'h0, o_rsp_valid}, 32'h1);
        check("basic_result", o_rsp_result, 32'd12);
        check("basic_tag", {28'h0, o_rsp_tag}, 32'd3);
        @(posedge i_clk);
        #1;
        check("basic_count", {16'h0, o_count}, 32'd1);

        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag,
                 vecs[i].exp_wrap, vecs[i].exp_sat, vecs[i].exp_ovf);
        end
        drain();
        check("table_count", {16'h0, o_count}, 32'd9);

        // Back-pressure: third request held, head stable, then ordered drain
        i_rsp_ready = 1'b0;
        cnt_base    = model_cnt;
        send(1'b0, 32'd10, 32'd1, 4'd1, 32'd11, 32'd11, 1'b0);
        send(1'b0, 32'd20, 32'd2, 4'd2, 32'd22, 32'd22, 1'b0);
        check("bp_ready_low", {31'h0, o_req_ready}, 32'h0);
        check("bp_head_tag", {28'h0, o_rsp_tag}, 32'd1);
        fork
            begin
                send(1'b1, 32'd30, 32'd3, 4'd3, 32'd27, 32'd27, 1'b0);
                bg_done = 1'b1;
            end
        join_none
        repeat (3) @(posedge i_clk);
        #1;
        check("bp_hold_tag", {28'h0, o_rsp_tag}, 32'd1);
        check("bp_hold_result", o_rsp_result, 32'd11);
        check("bp_hold_ready", {31'h0, o_req_ready}, 32'h0);
        check("bp_hold_count", {16'h0, o_count}, {16'h0, cnt_base});
        i_rsp_ready = 1'b1;
        for (int c = 0; c < 50 && !bg_done; c++) @(posedge i_clk);
        check("bp_third_accepted", {31'h0, bg_done}, 32'h1);
        drain();
        check("bp_count", {16'h0, o_count}, {16'h0, cnt_base + 16'd3});

        // Reset with two entries stored
        i_rsp_ready = 1'b0;
        send(1'b0, 32'd1, 32'd1, 4'd12, 32'd2, 32'd2, 1'b0);
        send(1'b0, 32'd2, 32'd2, 4'd13, 32'd4, 32'd4, 1'b0);
        check("pre_rst_valid", {31'h0, o_rsp_valid}, 32'h1);
        check("pre_rst_ready", {31'h0, o_req_ready}, 32'h0);
        @(posedge i_clk);
        #2;
        i_arst_n = 1'b0;
        #1;
        exp_q.delete();
        model_cnt = '0;
        check("midrst_valid", {31'h0, o_rsp_valid}, 32'h0);
        check("midrst_ready", {31'h0, o_req_ready}, 32'h1);
        check("midrst_count", {16'h0, o_count}, 32'h0);
        check("midrst_result", o_rsp_result, 32'h0);
        @(posedge i_clk);
        #3;
        i_arst_n    = 1'b1;
        i_rsp_ready = 1'b1;
        send(1'b1, 32'd100, 32'd1, 4'd14, 32'd99, 32'd99, 1'b0);
        check("postrst_valid", {31'h0, o_rsp_valid}, 32'h1);
        check("postrst_result", o_rsp_result, 32'd99);
        check("postrst_tag", {28'h0, o_rsp_tag}, 32'd14);
        drain();
        check("postrst_count", {16'h0, o_count}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arith_responder.md
# arith_responder

Sequential responder for the add/subtract service. Callers issue operand pairs with an operation select over a valid/ready request channel. The block computes the signed 32-bit sum or difference, buffers results in an in-order response FIFO, and returns each result with its tag and an overflow flag over a valid/ready response channel. It sits between interface-side callers and the arithmetic datapath, and replaces per-call combinational evaluation with a registered, back-pressured service.

## Interface
- DEPTH, default 2: response FIFO entries; legal range 1..8.
- TAG_W, default 4: request/response tag width.
- i_clk  input  1  clock; all state updates on rising edge.
- i_arst_n  input  1  asynchronous reset, active low.
- i_req_valid  input  1  request present.
- o_req_ready  output  1  block can accept a request this cycle.
- i_req_op  input  1  0 = add (i_a + i_b), 1 = subtract (i_a - i_b).
- i_a  input  32  signed operand A.
- i_b  input  32  signed operand B.
- i_req_tag  input  TAG_W  caller tag, returned unchanged.
- o_rsp_valid  output  1  response present.
- i_rsp_ready  input  1  caller accepts the response.
- o_rsp_result  output  32  signed result.
- o_rsp_tag  output  TAG_W  tag of the head response.
- o_rsp_ovf  output  1  signed 32-bit overflow occurred for the head response.
- o_count  output  16  number of completed response handshakes, modulo 2^16.

Decided: one clock (i_clk). Reset i_arst_n is asynchronous and active-low.

## Operation
- Request handshake: a request is accepted when i_req_valid && o_req_ready on a clock edge.
- o_req_ready = (occupancy < DEPTH). It is registered-state only, with no combinational path from i_rsp_ready.
- On acceptance, the result is computed in 33-bit signed arithmetic. o_rsp_ovf = (bit 32 != bit 31) of the 33-bit result. The entry {result[31:0], tag, ovf} is written at the write pointer.
- Response handshake: pops the head entry when o_rsp_valid && i_rsp_ready. o_rsp_valid = (occupancy > 0).
- Head outputs come directly from FIFO storage at the read pointer. They remain stable while o_rsp_valid && !i_rsp_ready.
- Occupancy state: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
  - Push only: occupancy +1.
  - Pop only: occupancy -1.
  - Push and pop in the same cycle: occupancy unchanged. This is possible in EMPTY->no (no pop when empty) and in PARTIAL. It is impossible in FULL, because ready is low.
- Pointers increment modulo DEPTH (DEPTH-1 wraps to 0). DEPTH need not be a power of two.
- Ordering: responses are strictly in acceptance order.
- o_count increments by 1 on every response handshake and wraps 0xFFFF -> 0x0000.
- Reset: asynchronous assertion discards all entries immediately, including those mid-transfer. Outputs take reset values while i_arst_n is low.

## Timing
- Reset values:
  - o_req_ready = 1
  - o_rsp_valid = 0
  - o_rsp_result = 0
  - o_rsp_tag = 0
  - o_rsp_ovf = 0
  - o_count = 0
- Latency: a request accepted at edge N is visible on o_rsp_valid/o_rsp_result after edge N, i.e. in cycle N+1. There is no same-cycle bypass.
- Throughput: one request and one response per cycle when the FIFO is PARTIAL, or when DEPTH >= 2 and the caller is always ready.
- With DEPTH = 1, throughput is 1 per 2 cycles, since ready drops while the single entry is held.
- A push into FULL cannot occur. A pop from EMPTY cannot occur.
- After reset deassertion, the first request can be accepted on the first rising edge.

## Configuration
- ARITH_RESP_SAT_EN defined:
  - On overflow, the stored result saturates: 0x7FFFFFFF for positive overflow (bit 32 = 0), 0x80000000 for negative overflow (bit 32 = 1).
  - o_rsp_ovf is still set.
- Not defined:
  - The result is the two's-complement wrap of the 33-bit sum or difference (bits 31:0).
  - o_rsp_ovf is set identically.

## Test plan
- Basic add: add 5 + 7, tag 3, i_rsp_ready = 1 -> next cycle o_rsp_valid = 1, result 12, tag 3, ovf 0, then o_count = 1.
- Subtract: subtract 5 - 7 -> result 0xFFFFFFFE (-2), ovf 0.
- Overflow: add 0x7FFFFFFF + 1 -> ovf 1.
  - Result 0x80000000 without ARITH_RESP_SAT_EN.
  - Result 0x7FFFFFFF with ARITH_RESP_SAT_EN.
- Negative overflow: subtract 0x80000000 - 1 -> ovf 1, result 0x7FFFFFFF (wrap) or 0x80000000 (sat).
- Back-pressure with DEPTH = 2, i_rsp_ready = 0:
  - Push tags 1, 2, 3 back-to-back.
  - o_req_ready drops after two accepts, and tag 3 is held.
  - Head stays at tag 1, unchanged.
  - Raise i_rsp_ready: responses arrive in order 1, 2, 3, and o_count = 3.
- Reset mid-operation:
  - Assert i_arst_n low with 2 entries stored and o_count = 5.
  - Immediately o_rsp_valid = 0, o_req_ready = 1, o_count = 0.
  - After release, the next request returns a correct result after one cycle.
